// File: rtl/axi_posted_wr_buffer.sv
// rtl/axi_posted_wr_buffer.sv - posted-write buffer between the MMU data AXI master and the L2 S1 port
module axi_posted_wr_buffer #(
    parameter int DEPTH  = 4,
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [ID_W-1:0]   s_awid,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic [7:0]        s_awlen,
    input  logic [2:0]        s_awsize,
    input  logic [1:0]        s_awburst,
    input  logic [3:0]        s_awcache,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    input  logic              s_wlast,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [ID_W-1:0]   s_bid,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    output logic [ID_W-1:0]   m_awid,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic [7:0]        m_awlen,
    output logic [2:0]        m_awsize,
    output logic [1:0]        m_awburst,
    output logic [3:0]        m_awcache,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    output logic              m_wlast,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [ID_W-1:0]   m_bid,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic              m_arvalid,
    input  logic              m_arready,
    output logic              wr_err
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = 1;

    typedef enum logic [1:0] {D_IDLE, D_ADDR, D_RESP} dstate_t;
    typedef enum logic [1:0] {P_IDLE, P_WAIT, P_XFER, P_RESP} pstate_t;

    logic [ID_W-1:0]   r_id    [DEPTH];
    logic [ADDR_W-1:0] r_addr  [DEPTH];
    logic [2:0]        r_size  [DEPTH];
    logic [1:0]        r_burst [DEPTH];
    logic [3:0]        r_cache [DEPTH];
    logic [31:0]       r_data  [DEPTH];
    logic [3:0]        r_strb  [DEPTH];

    logic [PW-1:0]   r_wptr, r_rptr;
    logic [CW-1:0]   r_count;
    logic            r_b_pend;
    logic [ID_W-1:0] r_bid;
    dstate_t         r_dstate;
    pstate_t         r_pstate;
    logic            r_awv, r_wv, r_aw_done, r_wr_err;

    logic w_full, w_empty, w_push, w_pop, w_xfer, w_presp, w_hit;
    logic w_unused;

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    // Full is judged on the registered count, so a pop never makes room in its own cycle.
    assign w_push   = aresetn && s_awvalid && s_wvalid && (s_awlen == 8'd0) && !w_full
                      && !r_b_pend && (r_pstate == P_IDLE);
    assign w_pop    = (r_dstate == D_RESP) && m_bvalid;
    assign w_xfer   = (r_pstate == P_XFER);
    assign w_presp  = (r_pstate == P_RESP);
    assign wr_err   = r_wr_err;
    assign w_unused = ^s_araddr[1:0];

    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_id[r_wptr]    <= s_awid;
            r_addr[r_wptr]  <= s_awaddr;
            r_size[r_wptr]  <= s_awsize;
            r_burst[r_wptr] <= s_awburst;
            r_cache[r_wptr] <= s_awcache;
            r_data[r_wptr]  <= s_wdata;
            r_strb[r_wptr]  <= s_wstrb;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wptr   <= '0;
            r_count  <= '0;
            r_b_pend <= 1'b0;
            r_bid    <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_push) begin
                r_b_pend <= 1'b1;
                r_bid    <= s_awid;
            end else if (r_b_pend && s_bready) begin
                r_b_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_dstate <= D_IDLE;
            r_awv    <= 1'b0;
            r_wv     <= 1'b0;
            r_rptr   <= '0;
            r_wr_err <= 1'b0;
        end else begin
            case (r_dstate)
                D_IDLE: if (!w_empty) begin
                    r_dstate <= D_ADDR;
                    r_awv    <= 1'b1;
                    r_wv     <= 1'b1;
                end
                D_ADDR: begin
                    if (m_awready) r_awv <= 1'b0;
                    if (m_wready)  r_wv  <= 1'b0;
                    if ((!r_awv || m_awready) && (!r_wv || m_wready)) r_dstate <= D_RESP;
                end
                D_RESP: if (m_bvalid) begin
                    r_rptr   <= r_rptr + PTR_ONE;
                    r_dstate <= D_IDLE;
                    if (m_bresp != 2'b00) r_wr_err <= 1'b1;
                end
                default: r_dstate <= D_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_pstate  <= P_IDLE;
            r_aw_done <= 1'b0;
        end else begin
            case (r_pstate)
                P_IDLE: if (s_awvalid && s_awlen != 8'd0) r_pstate <= P_WAIT;
                P_WAIT: if (w_empty && r_dstate == D_IDLE && !r_b_pend) begin
                    r_pstate  <= P_XFER;
                    r_aw_done <= 1'b0;
                end
                P_XFER: begin
                    if (s_awvalid && m_awready && !r_aw_done) r_aw_done <= 1'b1;
                    if (s_wvalid && m_wready && s_wlast && r_aw_done) r_pstate <= P_RESP;
                end
                P_RESP: if (m_bvalid && s_bready) r_pstate <= P_IDLE;
                default: r_pstate <= P_IDLE;
            endcase
        end
    end

    // W beats of a pass-through burst are held until its AW has gone, so wlast always follows AW.
    always_comb begin
        s_awready = w_push | (w_xfer & m_awready & ~r_aw_done);
        s_wready  = w_push | (w_xfer & m_wready & r_aw_done);
        s_bvalid  = w_presp ? m_bvalid : r_b_pend;
        s_bid     = w_presp ? m_bid : r_bid;
        s_bresp   = w_presp ? m_bresp : 2'b00;
        m_bready  = w_presp ? s_bready : (r_dstate == D_RESP);
        if (w_xfer) begin
            m_awid    = s_awid;
            m_awaddr  = s_awaddr;
            m_awlen   = s_awlen;
            m_awsize  = s_awsize;
            m_awburst = s_awburst;
            m_awcache = s_awcache;
            m_awvalid = s_awvalid & ~r_aw_done;
            m_wdata   = s_wdata;
            m_wstrb   = s_wstrb;
            m_wlast   = s_wlast;
            m_wvalid  = s_wvalid & r_aw_done;
        end else begin
            m_awid    = r_id[r_rptr];
            m_awaddr  = r_addr[r_rptr];
            m_awlen   = 8'd0;
            m_awsize  = r_size[r_rptr];
            m_awburst = r_burst[r_rptr];
            m_awcache = r_cache[r_rptr];
            m_awvalid = r_awv;
            m_wdata   = r_data[r_rptr];
            m_wstrb   = r_strb[r_rptr];
            m_wlast   = 1'b1;
            m_wvalid  = r_wv;
        end
    end

    always_comb begin
        w_hit = (r_pstate != P_IDLE);
        for (int i = 0; i < DEPTH; i++) begin
            if (({1'b0, PW'(i) - r_rptr} < r_count)
                && (r_addr[i][ADDR_W-1:2] == s_araddr[ADDR_W-1:2]))
                w_hit = 1'b1;
        end
    end

    assign m_arvalid = aresetn & s_arvalid & ~w_hit;
    assign s_arready = aresetn & m_arready & ~w_hit;
endmodule
